register_file_writeback: RTL and testbench

Write-back consumer and architectural register file for the five-stage RISC-V pipeline. Takes the registered WB-stage bundle, selects the final result, and commits it to the 32×32 integer register file. Serves the two decode-stage read ports, with optional same-cycle write-to-read bypass, and keeps a wrap-around count of committed register writes for debug and performance.

---
 rtl/register_file_writeback.sv | 87 ++++++++
 tb/tb_register_file_writeback.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_writeback.sv
// Write-back result select, 32x32 integer register file with two decode read ports,
// and a wrap-around commit counter. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module register_file_writeback #(
   parameter int XLEN = 32,
   parameter int REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteW,
   input  logic [1:0]      ResultSrcW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ALUResultW,
   input  logic [XLEN-1:0] DataMemoryOutW,
   input  logic [XLEN-1:0] PCPlus4W,
   input  logic [XLEN-1:0] ExtImmW,
   input  logic [4:0]      A1D,
   input  logic [4:0]      A2D,
   output logic [XLEN-1:0] ResultW,
   output logic [XLEN-1:0] RD1D,
   output logic [XLEN-1:0] RD2D,
   output logic [31:0]     WriteCount
);

   typedef enum logic [1:0] {
      SRC_ALU = 2'b00,
      SRC_MEM = 2'b01,
      SRC_PC4 = 2'b10,
      SRC_IMM = 2'b11
   } result_src_e;

   // x0 is not stored; entries exist only for 1..REGS-1.
   logic [XLEN-1:0] regs [1:REGS-1];
   logic [31:0]     write_count;
   logic            commit;

   // NOTE: every variable written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      ResultW = ALUResultW;
      case (result_src_e'(ResultSrcW))
         SRC_ALU: ResultW = ALUResultW;
         SRC_MEM: ResultW = DataMemoryOutW;
         SRC_PC4: ResultW = PCPlus4W;
         SRC_IMM: ResultW = ExtImmW;
      endcase
   end

   // Reset low also blocks the commit, which suppresses the bypass below.
   assign commit = rst && RegWriteW && (RDW != 5'd0) && (int'(RDW) < REGS);

   // NOTE: the array is cleared by reset because architectural state must read 0
   // after reset; this keeps it in flops rather than a RAM macro, which is fine at 31 entries.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 1; i < REGS; i++) begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            regs[i] <= '0;
         end
         write_count <= '0;
      end else if (commit) begin
         regs[RDW]   <= ResultW;
         write_count <= write_count + 32'd1;
      end
   end

   assign WriteCount = write_count;

   function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
      logic [XLEN-1:0] data;
      data = '0;
      if (addr != 5'd0 && int'(addr) < REGS) begin
         data = regs[addr];
`ifdef REGFILE_BYPASS_EN
         if (commit && addr == RDW) begin
            data = ResultW;
         end
`endif
      end
      return data;
   endfunction

   always_comb begin
      RD1D = read_port(A1D);
      RD2D = read_port(A2D);
   end

endmodule

// File: tb/tb_register_file_writeback.sv
// Scoreboard bench for register_file_writeback: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_register_file_writeback;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      SIG_RESULT = 2'd0,
      SIG_RD1    = 2'd1,
      SIG_RD2    = 2'd2,
      SIG_WCOUNT = 2'd3
   } sig_e;

   typedef struct {
      string       name;
      sig_e        sig;
      logic [31:0] exp;
   } sb_item_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            RegWriteW;
   logic [1:0]      ResultSrcW;
   logic [4:0]      RDW;
   logic [XLEN-1:0] ALUResultW, DataMemoryOutW, PCPlus4W, ExtImmW;
   logic [4:0]      A1D, A2D;
   logic [XLEN-1:0] ResultW, RD1D, RD2D;
   logic [31:0]     WriteCount;

   sb_item_t sb [$];
   int tests_run = 0;
   int tests_failed = 0;

   register_file_writeback #(.XLEN(XLEN), .REGS(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .RegWriteW      (RegWriteW),
      .ResultSrcW     (ResultSrcW),
      .RDW            (RDW),
      .ALUResultW     (ALUResultW),
      .DataMemoryOutW (DataMemoryOutW),
      .PCPlus4W       (PCPlus4W),
      .ExtImmW        (ExtImmW),
      .A1D            (A1D),
      .A2D            (A2D),
      .ResultW        (ResultW),
      .RD1D           (RD1D),
      .RD2D           (RD2D),
      .WriteCount     (WriteCount)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are combinational, so every queued item is due at the next negedge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         sb_item_t it;
         logic [31:0] act;
         it = sb.pop_front();
         case (it.sig)
            SIG_RESULT: act = ResultW;
            SIG_RD1:    act = RD1D;
            SIG_RD2:    act = RD2D;
            default:    act = WriteCount;
         endcase
         tests_run++;
         if (act !== it.exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
         end
      end
   end

   task automatic expect_out(input string name, input sig_e sig, input logic [31:0] exp);
      sb_item_t it;
      it.name = name;
      it.sig  = sig;
      it.exp  = exp;
      sb.push_back(it);
   endtask

   // Advance one rising edge; inputs change 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00; RDW = 5'd0;
      ALUResultW = '0; DataMemoryOutW = '0; PCPlus4W = '0; ExtImmW = '0;
      A1D = 5'd0; A2D = 5'd0;

      // Reset held for two edges, then sweep both read ports.
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         A1D = 5'(i);
         A2D = 5'(31 - i);
         expect_out($sformatf("reset_rd1_x%0d", i), SIG_RD1, 32'h0);
         expect_out($sformatf("reset_rd2_x%0d", 31 - i), SIG_RD2, 32'h0);
         if (i == 0) expect_out("reset_wcount", SIG_WCOUNT, 32'd0);
         step();
      end

      // Result select: one encoding per destination x5..x8.
      ALUResultW = 32'h11; DataMemoryOutW = 32'h22; PCPlus4W = 32'h33; ExtImmW = 32'h44;
      RegWriteW = 1'b1;
      A1D = 5'd0; A2D = 5'd0;
      for (int s = 0; s < 4; s++) begin
         ResultSrcW = 2'(s);
         RDW = 5'(5 + s);
         expect_out($sformatf("result_sel_%0d", s), SIG_RESULT, 32'h11 * (s + 1));
         step();
      end
      RegWriteW = 1'b0;
      A1D = 5'd5; A2D = 5'd6;
      expect_out("sel_x5", SIG_RD1, 32'h11);
      expect_out("sel_x6", SIG_RD2, 32'h22);
      step();
      A1D = 5'd7; A2D = 5'd8;
      expect_out("sel_x7", SIG_RD1, 32'h33);
      expect_out("sel_x8", SIG_RD2, 32'h44);
      expect_out("sel_wcount", SIG_WCOUNT, 32'd4);
      step();

      // x0 protection, including the bypass path.
      RegWriteW = 1'b1; RDW = 5'd0; ResultSrcW = 2'b00; ALUResultW = 32'hDEADBEEF;
      A1D = 5'd0; A2D = 5'd5;
      expect_out("x0_result", SIG_RESULT, 32'hDEADBEEF);
      expect_out("x0_before", SIG_RD1, 32'h0);
      expect_out("x0_other_port", SIG_RD2, 32'h11);
      step();
      RegWriteW = 1'b0;
      expect_out("x0_after", SIG_RD1, 32'h0);
      expect_out("x0_wcount", SIG_WCOUNT, 32'd4);
      step();

      // Same-cycle read of the write target on both ports.
      RegWriteW = 1'b1; RDW = 5'd9; ALUResultW = 32'hCAFEF00D;
      A1D = 5'd9; A2D = 5'd9;
`ifdef REGFILE_BYPASS_EN
      expect_out("x9_same_rd1", SIG_RD1, 32'hCAFEF00D);
      expect_out("x9_same_rd2", SIG_RD2, 32'hCAFEF00D);
`else
      expect_out("x9_same_rd1", SIG_RD1, 32'h0);
      expect_out("x9_same_rd2", SIG_RD2, 32'h0);
`endif
      step();
      RegWriteW = 1'b0;
      expect_out("x9_next_rd1", SIG_RD1, 32'hCAFEF00D);
      expect_out("x9_next_rd2", SIG_RD2, 32'hCAFEF00D);
      expect_out("x9_wcount", SIG_WCOUNT, 32'd5);
      step();

      // Preload x3, then reset in the same cycle as a write to x3.
      RegWriteW = 1'b1; RDW = 5'd3; ALUResultW = 32'h77;
      step();
      rst = 1'b0; RDW = 5'd3; ALUResultW = 32'h1234;
      A1D = 5'd3; A2D = 5'd9;
      expect_out("rst_no_bypass_x3", SIG_RD1, 32'h77);
      expect_out("rst_array_x9", SIG_RD2, 32'hCAFEF00D);
      expect_out("rst_wcount_before", SIG_WCOUNT, 32'd6);
      step();
      rst = 1'b1; RegWriteW = 1'b0;
      expect_out("rst_override_x3", SIG_RD1, 32'h0);
      expect_out("rst_clear_x9", SIG_RD2, 32'h0);
      expect_out("rst_override_wcount", SIG_WCOUNT, 32'd0);
      step();

      // Counter wrap: preload the counter to all ones, then commit once.
      force dut.write_count = 32'hFFFF_FFFF;
      #1;
      release dut.write_count;
      expect_out("wrap_preload", SIG_WCOUNT, 32'hFFFF_FFFF);
      step();
      RegWriteW = 1'b1; RDW = 5'd10; ResultSrcW = 2'b00; ALUResultW = 32'h5A;
      A1D = 5'd10; A2D = 5'd0;
      step();
      RegWriteW = 1'b0;
      expect_out("wrap_x10", SIG_RD1, 32'h5A);
      expect_out("wrap_wcount", SIG_WCOUNT, 32'h0);
      step();

      // Drain: anything still queued means the monitor never reached it.
      repeat (2) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d items left, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
